mac_seq_ctrl: RTL

Sequencer for the `mac_array` systolic datapath. It accepts one job command and drives the array's `inst[1:0]` through three phases: weight load, settle gap, then activation execute. It also generates the L0 input-buffer read strobe, throttles on L0-empty and output-FIFO-full, and reports completion once the last partial sums have drained. It sits between the core top-level control and the `mac_array`/L0/OFIFO instances.

---
 rtl/mac_seq_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: job sequencer for the mac_array systolic datapath.
// Drives weight load, settle gap, activation execute and drain phases, generates the L0 read
// strobe and throttles on L0-empty / OFIFO-full.
// Optional stall counter: define MAC_SEQ_CTRL_PERF_EN to build perf_stall, otherwise it is 0.
module mac_seq_ctrl #(
    parameter int unsigned col = 8,
    parameter int unsigned cw  = 10,
    parameter int unsigned pw  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [cw-1:0] n_vec,
    input  logic          sign_mode_in,
    input  logic          width_mode_in,
    input  logic          l0_empty,
    input  logic          ofifo_full,
    output logic          l0_rd,
    output logic [1:0]    inst,
    output logic          sign_mode,
    output logic          width_mode,
    output logic          busy,
    output logic          done,
    output logic [pw-1:0] perf_stall
);

    // Counter must reach col+1 (drain) and n_vec-1 / n_vec (execute) without wrapping.
    localparam int unsigned CntMinW = $clog2(col + 3);
    localparam int unsigned CntW    = (CntMinW > cw) ? CntMinW : cw;
    localparam logic [CntW-1:0] ColLast   = CntW'(col - 1);
    localparam logic [CntW-1:0] DrainLast = CntW'(col + 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGap,
        StExec,
        StDrain,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [cw-1:0]   nvec_q, nvec_d;
    logic            sign_q, sign_d;
    logic            width_q, width_d;
    logic [1:0]      inst_q, inst_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_issue;
    logic            exec_issue;

    // Issue decisions; l0_rd fires in the issue cycle so L0 data lines up with registered inst.
    always_comb begin
        load_issue = (state_q == StLoad) && !l0_empty;
        exec_issue = (state_q == StExec) && !l0_empty && !ofifo_full;
        l0_rd      = load_issue || exec_issue;
    end

    // Next-state, phase counter and job latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nvec_d  = nvec_q;
        sign_d  = sign_q;
        width_d = width_q;
        cnt_inc = cnt_q + CntW'(1);
        case (state_q)
            StIdle: begin
                if (start) begin
                    nvec_d  = n_vec;
                    sign_d  = sign_mode_in;
                    width_d = width_mode_in;
                    cnt_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (load_issue) begin
                    if (cnt_q == ColLast) begin
                        cnt_d   = '0;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StGap: begin
                if (cnt_q == ColLast) begin
                    cnt_d   = '0;
                    state_d = (nvec_q == '0) ? StDrain : StExec;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StExec: begin
                if (exec_issue) begin
                    if (cnt_inc == CntW'(nvec_q)) begin
                        cnt_d   = '0;
                        state_d = StDrain;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        inst_d = {exec_issue, load_issue};
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and registered outputs; reset abandons any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            nvec_q  <= '0;
            sign_q  <= 1'b0;
            width_q <= 1'b0;
            inst_q  <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nvec_q  <= nvec_d;
            sign_q  <= sign_d;
            width_q <= width_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inst       = inst_q;
    assign sign_mode  = sign_q;
    assign width_mode = width_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef MAC_SEQ_CTRL_PERF_EN
    logic [pw-1:0] perf_q, perf_d;
    logic          stall;

    // Saturating count of LOAD/EXEC cycles that could not issue; cleared on job start.
    always_comb begin
        stall  = ((state_q == StLoad) && l0_empty) ||
                 ((state_q == StExec) && (l0_empty || ofifo_full));
        perf_d = perf_q;
        if ((state_q == StIdle) && start) begin
            perf_d = '0;
        end else if (stall && (perf_q != '1)) begin
            perf_d = perf_q + pw'(1);
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule
